// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU codes, write-back encodings, FSM states and instruction field layout
package cpu_pkg;

    localparam logic [5:0] ALU_NOP   = 6'd0;
    localparam logic [5:0] ALU_ADD   = 6'd1;
    localparam logic [5:0] ALU_SUB   = 6'd2;
    localparam logic [5:0] ALU_STORE = 6'd3;
    localparam logic [5:0] ALU_LOAD  = 6'd4;
    localparam logic [5:0] ALU_MOVE  = 6'd5;
    localparam logic [5:0] ALU_SGE   = 6'd6;
    localparam logic [5:0] ALU_SLE   = 6'd7;
    localparam logic [5:0] ALU_SGT   = 6'd8;
    localparam logic [5:0] ALU_SLT   = 6'd9;
    localparam logic [5:0] ALU_SEQ   = 6'd10;
    localparam logic [5:0] ALU_SNE   = 6'd11;
    localparam logic [5:0] ALU_AND   = 6'd12;
    localparam logic [5:0] ALU_OR    = 6'd13;
    localparam logic [5:0] ALU_XOR   = 6'd14;
    localparam logic [5:0] ALU_NOT   = 6'd15;
    localparam logic [5:0] ALU_MOVEI = 6'd16;
    localparam logic [5:0] ALU_SLI   = 6'd17;
    localparam logic [5:0] ALU_SRI   = 6'd18;
    localparam logic [5:0] ALU_ADDI  = 6'd19;
    localparam logic [5:0] ALU_SUBI  = 6'd20;
    localparam logic [5:0] ALU_LAST  = ALU_SUBI;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_CMP = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS_MSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_SEXT = 2'd1,
        IMM_ZEXT = 2'd2
    } imm_mode_t;

    typedef struct packed {
        logic [5:0] alu_code;
        imm_mode_t  imm_mode;
        logic [1:0] wb_sel;
        logic       writes_reg;
        logic       is_mem;
        logic       is_load;
        logic       is_cmp;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode to control-bundle decoder
module alu_op_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec          = '0;
        dec.imm_mode = IMM_NONE;
        dec.wb_sel   = WB_ALU;
        if (opcode > ALU_LAST) begin
            // Undefined opcodes collapse to a NOP that only raises the flag.
            dec.illegal = 1'b1;
        end else begin
            dec.alu_code   = opcode;
            dec.writes_reg = 1'b1;
            case (opcode)
                ALU_NOP: begin
                    dec.writes_reg = 1'b0;
                end
                ALU_STORE: begin
                    dec.writes_reg = 1'b0;
                    dec.is_mem     = 1'b1;
                    dec.imm_mode   = IMM_SEXT;
                end
                ALU_LOAD: begin
                    dec.is_mem   = 1'b1;
                    dec.is_load  = 1'b1;
                    dec.imm_mode = IMM_SEXT;
                    dec.wb_sel   = WB_MEM;
                end
                ALU_SGE, ALU_SLE, ALU_SGT, ALU_SLT, ALU_SEQ, ALU_SNE: begin
                    dec.is_cmp = 1'b1;
                    dec.wb_sel = WB_CMP;
                end
                ALU_MOVEI: begin
                    dec.imm_mode = IMM_SEXT;
                    dec.wb_sel   = WB_IMM;
                end
                ALU_ADDI, ALU_SUBI: begin
                    dec.imm_mode = IMM_SEXT;
                end
                ALU_SLI, ALU_SRI: begin
                    dec.imm_mode = IMM_ZEXT;
                end
                default: begin
                    dec.writes_reg = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_control_unit.sv
// rtl/alu_control_unit.sv - multi-cycle instruction sequencer driving ALU code and datapath enables
module alu_control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr,
    output logic              instr_ready,
    output logic [5:0]        alu_control,
    output logic [REG_AW-1:0] rs_addr,
    output logic [REG_AW-1:0] rt_addr,
    output logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] alu_result,
    output logic              mem_re,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [1:0]        wb_sel,
    output logic              cmp_flag,
    output logic              reg_we,
    output logic              illegal,
    output logic              busy
);

    state_t            state;
    dec_t              dec;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] imm_ext;
    logic              cur_writes;
    logic              cur_mem;
    logic              cur_load;
    logic              cur_cmp;

    alu_op_decode u_decode (
        .opcode (instr[OPC_MSB:OPC_LSB]),
        .dec    (dec)
    );

    assign imm16 = instr[IMM_MSB:IMM_LSB];

    always_comb begin
        imm_ext = '0;
        case (dec.imm_mode)
            IMM_SEXT: imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
            IMM_ZEXT: imm_ext = {{(DATA_W-16){1'b0}}, imm16};
            default:  imm_ext = '0;
        endcase
    end

    // alu_result is treated as the signed difference of the compared operands.
    function automatic logic cmp_eval(input logic [5:0] code, input logic [DATA_W-1:0] r);
        logic neg;
        logic zero;
        neg  = r[DATA_W-1];
        zero = (r == '0);
        case (code)
            ALU_SGE, ALU_SLE: cmp_eval = !neg;
            ALU_SGT, ALU_SLT: cmp_eval = !neg && !zero;
            ALU_SEQ:          cmp_eval = zero;
            ALU_SNE:          cmp_eval = !zero;
            default:          cmp_eval = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            instr_ready <= 1'b1;
            alu_control <= ALU_NOP;
            rs_addr     <= '0;
            rt_addr     <= '0;
            rd_addr     <= '0;
            imm         <= '0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            wb_sel      <= WB_ALU;
            cmp_flag    <= 1'b0;
            reg_we      <= 1'b0;
            illegal     <= 1'b0;
            busy        <= 1'b0;
            cur_writes  <= 1'b0;
            cur_mem     <= 1'b0;
            cur_load    <= 1'b0;
            cur_cmp     <= 1'b0;
        end else begin
            reg_we  <= 1'b0;
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        state       <= ST_DECODE;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        alu_control <= dec.alu_code;
                        illegal     <= dec.illegal;
                        wb_sel      <= dec.wb_sel;
                        imm         <= imm_ext;
                        rd_addr     <= REG_AW'(instr[RD_MSB:RD_LSB]);
                        rs_addr     <= REG_AW'(instr[RS_MSB:RS_LSB]);
                        rt_addr     <= REG_AW'(instr[RT_MSB:RT_LSB]);
                        cur_writes  <= dec.writes_reg;
                        cur_mem     <= dec.is_mem;
                        cur_load    <= dec.is_load;
                        cur_cmp     <= dec.is_cmp;
                    end
                end
                ST_DECODE: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    cmp_flag <= cur_cmp ? cmp_eval(alu_control, alu_result) : 1'b0;
                    if (cur_mem) begin
                        state  <= ST_MEM;
                        mem_re <= cur_load;
                        mem_we <= !cur_load;
                    end else if (cur_writes) begin
                        state  <= ST_WB;
                        reg_we <= 1'b1;
                    end else begin
                        state       <= ST_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        alu_control <= ALU_NOP;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        if (cur_load) begin
                            state  <= ST_WB;
                            reg_we <= 1'b1;
                        end else begin
                            state       <= ST_IDLE;
                            instr_ready <= 1'b1;
                            busy        <= 1'b0;
                            alu_control <= ALU_NOP;
                        end
                    end
                end
                ST_WB: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    alu_control <= ALU_NOP;
                end
                default: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    alu_control <= ALU_NOP;
                    mem_re      <= 1'b0;
                    mem_we      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// tb/tb_alu_control_unit.sv - scoreboard bench with random instructions against a behavioural model
module tb_alu_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] alu_result = '0;
    logic        mem_ack = 1'b0;
    logic        instr_ready;
    logic [5:0]  alu_control;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] imm;
    logic        mem_re, mem_we;
    logic [1:0]  wb_sel;
    logic        cmp_flag, reg_we, illegal, busy;

    always #5 clk = ~clk;

    alu_control_unit #(.DATA_W(32), .REG_AW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_control (alu_control),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rd_addr     (rd_addr),
        .imm         (imm),
        .alu_result  (alu_result),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .wb_sel      (wb_sel),
        .cmp_flag    (cmp_flag),
        .reg_we      (reg_we),
        .illegal     (illegal),
        .busy        (busy)
    );

    typedef struct {
        int          alu;
        int          rd;
        int          rs;
        int          rt;
        logic [31:0] imm;
        int          wb;
        int          ill;
        int          we_at;
        int          re_cyc;
        int          we_cyc;
        int          busy_cyc;
        int          is_cmp;
        int          cmp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   ack_delay = 0;
    bit   stray_en = 1'b0;
    bit   ack_poke = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] res, input int d);
        exp_t e;
        int   op;
        bit   legal, writes, is_mem;
        op     = int'(w[31:26]);
        legal  = (op <= 20);
        e.alu  = legal ? op : 0;
        e.rd   = int'(w[25:21]);
        e.rs   = int'(w[20:16]);
        e.rt   = int'(w[15:11]);
        if (op == 3 || op == 4 || op == 16 || op == 19 || op == 20)
            e.imm = {{16{w[15]}}, w[15:0]};
        else if (op == 17 || op == 18)
            e.imm = {16'h0000, w[15:0]};
        else
            e.imm = 32'h0;
        e.is_cmp   = (op >= 6 && op <= 11) ? 1 : 0;
        e.wb       = (e.is_cmp != 0) ? 2 : (op == 4) ? 1 : (op == 16) ? 3 : 0;
        e.ill      = legal ? 0 : 1;
        writes     = legal && op != 0 && op != 3;
        is_mem     = (op == 3 || op == 4);
        e.re_cyc   = (op == 4) ? d + 1 : 0;
        e.we_cyc   = (op == 3) ? d + 1 : 0;
        e.busy_cyc = 2 + (is_mem ? d + 1 : 0) + (writes ? 1 : 0);
        e.we_at    = writes ? e.busy_cyc - 1 : -1;
        case (op)
            6, 7:    e.cmp = ($signed(res) >= 0) ? 1 : 0;
            8, 9:    e.cmp = ($signed(res) > 0) ? 1 : 0;
            10:      e.cmp = (res == 0) ? 1 : 0;
            11:      e.cmp = (res != 0) ? 1 : 0;
            default: e.cmp = 0;
        endcase
        return e;
    endfunction

    task automatic send(input logic [31:0] w, input logic [31:0] res, input int d,
                        input bit track, input int hold);
        int t;
        t = 0;
        @(negedge clk);
        while (!instr_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
        end else begin
            instr       = w;
            alu_result  = res;
            ack_delay   = d;
            instr_valid = 1'b1;
            if (track) sb_q.push_back(model(w, res, d));
            repeat (hold + 1) @(posedge clk);
            #1 instr_valid = 1'b0;
        end
    endtask

    // Memory responder: acks after ack_delay strobe cycles, stray acks elsewhere.
    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (mem_re || mem_we) begin
                mem_ack = (k == ack_delay);
                k++;
            end else begin
                k = 0;
                mem_ack = ack_poke | (stray_en && ($urandom_range(3) == 0));
            end
        end
    end

    // Monitor: captures one instruction from first busy cycle to return to idle.
    initial begin
        bit          cap;
        int          cyc, ill_cnt, ill_pos, rwe_cnt, rwe_pos, re_n, we_n, hold_bad;
        logic [5:0]  g_alu;
        logic [4:0]  g_rd, g_rs, g_rt;
        logic [31:0] g_imm;
        logic [1:0]  g_wb;
        logic        g_cmp;
        exp_t        e;
        cap = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cap = 1'b0;
            end else begin
                if (busy && !cap) begin
                    cap = 1'b1; cyc = 0; hold_bad = 0;
                    ill_cnt = 0; ill_pos = -1; rwe_cnt = 0; rwe_pos = -1;
                    re_n = 0; we_n = 0; g_cmp = 1'b0;
                    g_alu = alu_control; g_rd = rd_addr; g_rs = rs_addr; g_rt = rt_addr;
                    g_imm = imm; g_wb = wb_sel;
                end
                if (cap && busy) begin
                    if (alu_control !== g_alu) hold_bad = 1;
                    if (illegal) begin ill_cnt++; ill_pos = cyc; end
                    if (reg_we) begin rwe_cnt++; rwe_pos = cyc; g_cmp = cmp_flag; end
                    if (mem_re) re_n++;
                    if (mem_we) we_n++;
                    cyc++;
                end else if (cap) begin
                    cap = 1'b0;
                    if (alu_control !== 6'd0 || reg_we || mem_re || mem_we) hold_bad = 1;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_txn", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("alu_control", {26'd0, g_alu}, e.alu);
                        chk("rd_addr", {27'd0, g_rd}, e.rd);
                        chk("rs_addr", {27'd0, g_rs}, e.rs);
                        chk("rt_addr", {27'd0, g_rt}, e.rt);
                        chk("imm", g_imm, e.imm);
                        chk("wb_sel", {30'd0, g_wb}, e.wb);
                        chk("illegal_count", ill_cnt, e.ill);
                        chk("illegal_pos", ill_pos, (e.ill != 0) ? 0 : -1);
                        chk("reg_we_count", rwe_cnt, (e.we_at >= 0) ? 1 : 0);
                        chk("reg_we_pos", rwe_pos, e.we_at);
                        chk("mem_re_cycles", re_n, e.re_cyc);
                        chk("mem_we_cycles", we_n, e.we_cyc);
                        chk("busy_cycles", cyc, e.busy_cyc);
                        chk("alu_control_hold", hold_bad, 0);
                        if (e.is_cmp != 0) chk("cmp_flag", {31'd0, g_cmp}, e.cmp);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] w, r, rnd;
        int          op, sel, t, bad;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_alu_control", {26'd0, alu_control}, 32'd0);
        chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_imm", imm, 32'd0);

        send({6'd1, 5'd3, 5'd1, 5'd2, 11'd0}, 32'h1234, 0, 1'b1, 0);
        send({6'd4, 5'd7, 5'd2, 16'hFFFC}, 32'h0, 4, 1'b1, 0);
        send({6'd3, 5'd7, 5'd2, 16'hFFFC}, 32'h0, 4, 1'b1, 0);
        send({6'd9, 5'd4, 5'd5, 5'd6, 11'd0}, 32'hFFFF_FFFF, 0, 1'b1, 0);
        send({6'd6, 5'd4, 5'd5, 5'd6, 11'd0}, 32'h0, 0, 1'b1, 0);
        send({6'h2A, 26'h155_5555}, 32'h0, 0, 1'b1, 0);
        send({6'd17, 5'd1, 5'd2, 16'h8001}, 32'h0, 0, 1'b1, 2);

        stray_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            op  = ($urandom_range(9) == 0) ? int'($urandom_range(63, 21)) : int'($urandom_range(20, 0));
            rnd = $urandom;
            w   = {op[5:0], rnd[25:0]};
            sel = int'($urandom_range(3));
            r   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'h1 : $urandom;
            send(w, r, int'($urandom_range(5)), 1'b1, int'($urandom_range(2)));
            repeat ($urandom_range(2)) @(posedge clk);
        end

        t = 0;
        while ((sb_q.size() != 0 || busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", t < 500 ? 32'd0 : 32'd1, 32'd0);
        stray_en = 1'b0;

        // Reset mid-store with instr_valid asserted alongside reset.
        send({6'd3, 5'd1, 5'd1, 16'h0010}, 32'h0, 30, 1'b0, 0);
        t = 0;
        while (!mem_we && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("mem_we_before_reset", {31'd0, mem_we}, 32'd1);
        #1;
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = {6'd1, 26'd0};
        @(negedge clk);
        chk("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_mid_alu", {26'd0, alu_control}, 32'd0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        instr_valid = 1'b0;
        ack_poke    = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || mem_we || mem_re || reg_we) bad++;
        end
        ack_poke = 1'b0;
        chk("late_ack_ignored", bad, 0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
